// File: rtl/cpu_axi_arbiter_pkg.sv
// rtl/cpu_axi_arbiter_pkg.sv - shared types, ID tags and strobe helper for the CPU/AXI arbiter
package cpu_axi_arbiter_pkg;

    localparam logic [3:0] ID_INST = 4'd0;
    localparam logic [3:0] ID_DATA = 4'd1;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_AR   = 2'd1,
        R_R    = 2'd2
    } r_state_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_AW   = 2'd1,
        W_B    = 2'd2
    } w_state_e;

    // Byte lanes for an SRAM-like store; wdata itself stays unshifted.
    function automatic logic [3:0] wstrb_gen(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            2'd0:    return 4'b0001 << offset;
            2'd1:    return 4'b0011 << offset;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/cpu_axi_arbiter_if.sv
// rtl/cpu_axi_arbiter_if.sv - AXI3 AR/R/AW/W/B channel bundle used by the arbiter
interface cpu_axi_arbiter_if;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [2:0]  arsize;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic [2:0]  awsize;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic        bvalid;
    logic        bready;

    modport master (
        output arid, araddr, arsize, arvalid, rready,
        output awaddr, awsize, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rid, rdata, rvalid, awready, wready, bvalid
    );

    modport slave (
        input  arid, araddr, arsize, arvalid, rready,
        input  awaddr, awsize, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rid, rdata, rvalid, awready, wready, bvalid
    );
endinterface

// File: rtl/cpu_axi_arbiter.sv
// rtl/cpu_axi_arbiter.sv - merges inst fetch and data SRAM-like ports onto one AXI3 master
module cpu_axi_arbiter
    import cpu_axi_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addrok,
    output logic        inst_dataok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addrok,
    output logic        data_dataok,
    output logic [31:0] data_rdata,
    output logic        wr_pending,
    cpu_axi_arbiter_if.master axi
);

    r_state_e    r_state_q, r_state_d;
    logic [3:0]  ar_id_q, ar_id_d;
    logic [31:0] ar_addr_q, ar_addr_d;
    logic [2:0]  ar_size_q, ar_size_d;
    logic        arvalid_q, arvalid_d;
    logic        rready_q, rready_d;

    w_state_e    w_state_q, w_state_d;
    logic [31:0] aw_addr_q, aw_addr_d;
    logic [2:0]  aw_size_q, aw_size_d;
    logic [31:0] w_data_q, w_data_d;
    logic [3:0]  w_strb_q, w_strb_d;
    logic        awvalid_q, awvalid_d;
    logic        wvalid_q, wvalid_d;
    logic        bready_q, bready_d;

    logic data_rd_acc, inst_rd_acc, data_wr_acc, data_rd_busy;
    logic r_fire, b_fire, rid_is_data, aw_done, w_done;
    logic unused_inst_inputs;

    assign unused_inst_inputs = ^{inst_wr, inst_wdata};

    // Loads wait for an idle write FSM so a load never overtakes a store.
    assign data_rd_acc  = !reset && (r_state_q == R_IDLE) && data_req && !data_wr && (w_state_q == W_IDLE);
    assign inst_rd_acc  = !reset && (r_state_q == R_IDLE) && inst_req && !data_rd_acc;
    assign data_rd_busy = (r_state_q != R_IDLE) && (ar_id_q == ID_DATA);
    assign data_wr_acc  = !reset && (w_state_q == W_IDLE) && data_req && data_wr && !data_rd_busy;
    assign r_fire       = !reset && (r_state_q == R_R) && axi.rvalid;
    assign b_fire       = !reset && (w_state_q == W_B) && axi.bvalid;
    assign rid_is_data  = (axi.rid == ID_DATA);

    always_comb begin
        r_state_d = r_state_q;
        ar_id_d   = ar_id_q;
        ar_addr_d = ar_addr_q;
        ar_size_d = ar_size_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        case (r_state_q)
            R_IDLE: begin
                if (data_rd_acc) begin
                    ar_id_d   = ID_DATA;
                    ar_addr_d = data_addr;
                    ar_size_d = {1'b0, data_size};
                    arvalid_d = 1'b1;
                    r_state_d = R_AR;
                end else if (inst_rd_acc) begin
                    ar_id_d   = ID_INST;
                    ar_addr_d = inst_addr;
                    ar_size_d = {1'b0, inst_size};
                    arvalid_d = 1'b1;
                    r_state_d = R_AR;
                end
            end
            R_AR: begin
                if (axi.arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    r_state_d = R_R;
                end
            end
            R_R: begin
                if (axi.rvalid) begin
                    rready_d  = 1'b0;
                    r_state_d = R_IDLE;
                end
            end
            default: begin
                arvalid_d = 1'b0;
                rready_d  = 1'b0;
                r_state_d = R_IDLE;
            end
        endcase
    end

    always_comb begin
        w_state_d = w_state_q;
        aw_addr_d = aw_addr_q;
        aw_size_d = aw_size_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        aw_done   = !awvalid_q || axi.awready;
        w_done    = !wvalid_q || axi.wready;
        case (w_state_q)
            W_IDLE: begin
                if (data_wr_acc) begin
                    aw_addr_d = data_addr;
                    aw_size_d = {1'b0, data_size};
                    w_data_d  = data_wdata;
                    w_strb_d  = wstrb_gen(data_size, data_addr[1:0]);
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    w_state_d = W_AW;
                end
            end
            W_AW: begin
                // AW and W complete independently, in either order.
                if (awvalid_q && axi.awready) awvalid_d = 1'b0;
                if (wvalid_q && axi.wready)   wvalid_d  = 1'b0;
                if (aw_done && w_done) begin
                    bready_d  = 1'b1;
                    w_state_d = W_B;
                end
            end
            W_B: begin
                if (axi.bvalid) begin
                    bready_d  = 1'b0;
                    w_state_d = W_IDLE;
                end
            end
            default: begin
                awvalid_d = 1'b0;
                wvalid_d  = 1'b0;
                bready_d  = 1'b0;
                w_state_d = W_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q <= R_IDLE;
            ar_id_q   <= ID_INST;
            ar_addr_q <= 32'd0;
            ar_size_q <= 3'd0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            w_state_q <= W_IDLE;
            aw_addr_q <= 32'd0;
            aw_size_q <= 3'd0;
            w_data_q  <= 32'd0;
            w_strb_q  <= 4'd0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            ar_id_q   <= ar_id_d;
            ar_addr_q <= ar_addr_d;
            ar_size_q <= ar_size_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            w_state_q <= w_state_d;
            aw_addr_q <= aw_addr_d;
            aw_size_q <= aw_size_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
        end
    end

    always_ff @(posedge clk) begin
        if (r_fire) assert (axi.rid == ID_INST || axi.rid == ID_DATA);
    end

    assign inst_addrok = inst_rd_acc;
    assign data_addrok = data_rd_acc || data_wr_acc;
    assign inst_dataok = r_fire && !rid_is_data;
    assign data_dataok = (r_fire && rid_is_data) || b_fire;
    assign inst_rdata  = axi.rdata;
    assign data_rdata  = axi.rdata;
    assign wr_pending  = (w_state_q != W_IDLE);

    assign axi.arid    = ar_id_q;
    assign axi.araddr  = ar_addr_q;
    assign axi.arsize  = ar_size_q;
    assign axi.arvalid = arvalid_q;
    assign axi.rready  = rready_q;
    assign axi.awaddr  = aw_addr_q;
    assign axi.awsize  = aw_size_q;
    assign axi.awvalid = awvalid_q;
    assign axi.wdata   = w_data_q;
    assign axi.wstrb   = w_strb_q;
    assign axi.wvalid  = wvalid_q;
    assign axi.bready  = bready_q;

endmodule

// File: tb/tb_cpu_axi_arbiter.sv
// tb/tb_cpu_axi_arbiter.sv - directed bench for cpu_axi_arbiter
module tb_cpu_axi_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req, inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr, inst_wdata;
    logic        inst_addrok, inst_dataok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic        data_addrok, data_dataok;
    logic [31:0] data_rdata;
    logic        wr_pending;

    int n_cmp  = 0;
    int n_fail = 0;

    cpu_axi_arbiter_if axi();

    cpu_axi_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .inst_req   (inst_req),
        .inst_wr    (inst_wr),
        .inst_size  (inst_size),
        .inst_addr  (inst_addr),
        .inst_wdata (inst_wdata),
        .inst_addrok(inst_addrok),
        .inst_dataok(inst_dataok),
        .inst_rdata (inst_rdata),
        .data_req   (data_req),
        .data_wr    (data_wr),
        .data_size  (data_size),
        .data_addr  (data_addr),
        .data_wdata (data_wdata),
        .data_addrok(data_addrok),
        .data_dataok(data_dataok),
        .data_rdata (data_rdata),
        .wr_pending (wr_pending),
        .axi        (axi)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_addr = 0; inst_wdata = 0;
        data_req = 0; data_wr = 0; data_size = 2'd2; data_addr = 0; data_wdata = 0;
        axi.arready = 0; axi.rid = 0; axi.rdata = 0; axi.rvalid = 0;
        axi.awready = 0; axi.wready = 0; axi.bvalid = 0;
        tick(); tick();
        #1;
        chk("rst_arvalid", axi.arvalid, 0);
        chk("rst_awvalid", axi.awvalid, 0);
        chk("rst_wvalid", axi.wvalid, 0);
        chk("rst_rready", axi.rready, 0);
        chk("rst_bready", axi.bready, 0);
        chk("rst_wr_pending", wr_pending, 0);
        inst_req = 1; inst_addr = 32'h1fc0_0000;
        #1;
        chk("rst_inst_addrok_gated", inst_addrok, 0);

        // Plain instruction fetch
        reset = 0;
        #1;
        chk("t1_inst_addrok", inst_addrok, 1);
        chk("t1_data_addrok", data_addrok, 0);
        tick(); inst_req = 0; #1;
        chk("t1_arvalid", axi.arvalid, 1);
        chk("t1_araddr", axi.araddr, 32'h1fc0_0000);
        chk("t1_arid", axi.arid, 0);
        chk("t1_arsize", axi.arsize, 3'b010);
        chk("t1_addrok_pulse", inst_addrok, 0);
        axi.arready = 1;
        tick(); axi.arready = 0; #1;
        chk("t1_arvalid_drop", axi.arvalid, 0);
        chk("t1_rready", axi.rready, 1);
        for (int i = 0; i < 2; i++) begin
            tick(); #1;
            chk("t1_no_early_dataok", inst_dataok, 0);
        end
        tick(); axi.rvalid = 1; axi.rid = 4'd0; axi.rdata = 32'h3c1d_0000; #1;
        chk("t1_inst_dataok", inst_dataok, 1);
        chk("t1_inst_rdata", inst_rdata, 32'h3c1d_0000);
        chk("t1_data_dataok", data_dataok, 0);
        tick(); axi.rvalid = 0; #1;
        chk("t1_rready_drop", axi.rready, 0);
        chk("t1_dataok_pulse", inst_dataok, 0);

        // Data load beats a simultaneous fetch
        inst_req = 1; inst_addr = 32'h1fc0_0004;
        data_req = 1; data_wr = 0; data_addr = 32'h8000_1000; data_size = 2'd2;
        #1;
        chk("t2_data_addrok", data_addrok, 1);
        chk("t2_inst_addrok_lose", inst_addrok, 0);
        tick(); data_req = 0; #1;
        chk("t2_arid", axi.arid, 1);
        chk("t2_araddr", axi.araddr, 32'h8000_1000);
        chk("t2_inst_stall_ar", inst_addrok, 0);
        axi.arready = 1;
        tick(); axi.arready = 0; #1;
        chk("t2_rready", axi.rready, 1);
        chk("t2_inst_stall_r", inst_addrok, 0);
        axi.rvalid = 1; axi.rid = 4'd1; axi.rdata = 32'hdead_beef; #1;
        chk("t2_data_dataok", data_dataok, 1);
        chk("t2_data_rdata", data_rdata, 32'hdead_beef);
        chk("t2_inst_dataok", inst_dataok, 0);
        chk("t2_inst_addrok_r", inst_addrok, 0);
        tick(); axi.rvalid = 0; #1;
        chk("t2_inst_addrok_after", inst_addrok, 1);
        chk("t2_data_dataok_pulse", data_dataok, 0);
        tick(); inst_req = 0; #1;
        chk("t2_arid_inst", axi.arid, 0);
        chk("t2_araddr_inst", axi.araddr, 32'h1fc0_0004);
        axi.arready = 1;
        tick(); axi.arready = 0; axi.rvalid = 1; axi.rid = 4'd0; axi.rdata = 32'h2408_0001; #1;
        chk("t2_inst_dataok", inst_dataok, 1);
        chk("t2_inst_rdata", inst_rdata, 32'h2408_0001);
        tick(); axi.rvalid = 0;

        // Halfword store with late awready, load held off behind it
        data_req = 1; data_wr = 1; data_size = 2'd1; data_addr = 32'h8000_0002; data_wdata = 32'h0000_1234;
        #1;
        chk("t3_data_addrok", data_addrok, 1);
        tick(); data_req = 0; data_wr = 0; #1;
        chk("t3_awvalid", axi.awvalid, 1);
        chk("t3_wvalid", axi.wvalid, 1);
        chk("t3_wstrb", axi.wstrb, 4'b1100);
        chk("t3_awaddr", axi.awaddr, 32'h8000_0002);
        chk("t3_awsize", axi.awsize, 3'b001);
        chk("t3_wdata", axi.wdata, 32'h0000_1234);
        chk("t3_wr_pending", wr_pending, 1);
        axi.wready = 1;
        tick(); axi.wready = 0; #1;
        chk("t3_wvalid_drop", axi.wvalid, 0);
        chk("t3_awvalid_hold", axi.awvalid, 1);
        data_req = 1; data_wr = 0; data_addr = 32'h8000_0000; data_size = 2'd2; #1;
        chk("t4_load_blocked_aw", data_addrok, 0);
        tick(); axi.awready = 1; #1;
        chk("t4_load_blocked_aw2", data_addrok, 0);
        tick(); axi.awready = 0; #1;
        chk("t3_awvalid_drop", axi.awvalid, 0);
        chk("t3_bready", axi.bready, 1);
        chk("t4_wr_pending_b", wr_pending, 1);
        chk("t4_load_blocked_b", data_addrok, 0);
        chk("t3_no_early_dataok", data_dataok, 0);
        tick(); #1;
        chk("t3_wait_b", data_dataok, 0);
        axi.bvalid = 1; #1;
        chk("t3_b_dataok", data_dataok, 1);
        chk("t4_load_blocked_bvalid", data_addrok, 0);
        tick(); axi.bvalid = 0; #1;
        chk("t3_bready_drop", axi.bready, 0);
        chk("t4_wr_pending_clear", wr_pending, 0);
        chk("t4_load_addrok", data_addrok, 1);
        chk("t3_dataok_once", data_dataok, 0);
        tick(); data_req = 0; #1;
        chk("t4_load_arid", axi.arid, 1);
        chk("t4_load_arvalid", axi.arvalid, 1);

        // Reset while the load sits in R_R
        axi.arready = 1;
        tick(); axi.arready = 0; #1;
        chk("t5_rready", axi.rready, 1);
        reset = 1; axi.rvalid = 1; axi.rid = 4'd1; axi.rdata = 32'h5555_aaaa; #1;
        chk("t5_no_dataok_in_reset", data_dataok, 0);
        tick(); reset = 0; axi.rvalid = 0; #1;
        chk("t5_arvalid_after_rst", axi.arvalid, 0);
        chk("t5_rready_after_rst", axi.rready, 0);
        inst_req = 1; inst_addr = 32'h1fc0_0008; #1;
        chk("t5_inst_addrok", inst_addrok, 1);
        tick(); inst_req = 0; #1;
        chk("t5_araddr", axi.araddr, 32'h1fc0_0008);
        axi.arready = 1;
        tick(); axi.arready = 0; axi.rvalid = 1; axi.rid = 4'd0; axi.rdata = 32'h0000_0001; #1;
        chk("t5_inst_dataok", inst_dataok, 1);
        tick(); axi.rvalid = 0;

        // Byte store and fetch accepted together; AW and W complete in the same cycle
        axi.awready = 1; axi.wready = 1;
        inst_req = 1; inst_addr = 32'h1fc0_000c;
        data_req = 1; data_wr = 1; data_size = 2'd0; data_addr = 32'h8000_0003; data_wdata = 32'h0000_00a5;
        #1;
        chk("t6_inst_addrok", inst_addrok, 1);
        chk("t6_data_addrok", data_addrok, 1);
        tick(); inst_req = 0; data_req = 0; data_wr = 0; #1;
        chk("t6_wstrb", axi.wstrb, 4'b1000);
        chk("t6_awvalid", axi.awvalid, 1);
        chk("t6_arvalid", axi.arvalid, 1);
        chk("t6_arid", axi.arid, 0);
        tick(); axi.awready = 0; axi.wready = 0; #1;
        chk("t6_awvalid_drop", axi.awvalid, 0);
        chk("t6_wvalid_drop", axi.wvalid, 0);
        chk("t6_bready", axi.bready, 1);
        axi.bvalid = 1; #1;
        chk("t6_data_dataok", data_dataok, 1);
        chk("t6_inst_dataok", inst_dataok, 0);
        tick(); axi.bvalid = 0; axi.arready = 1;
        tick(); axi.arready = 0; axi.rvalid = 1; axi.rid = 4'd0; axi.rdata = 32'h8c08_0000; #1;
        chk("t6_inst_dataok_r", inst_dataok, 1);
        chk("t6_inst_rdata", inst_rdata, 32'h8c08_0000);
        tick(); axi.rvalid = 0; #1;
        chk("t6_idle_rready", axi.rready, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
